// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, no parity.
// Mid-bit sampling off a 2-flop synchronized line; registered status pulses.
module uart_rx #(
  parameter int BAUD_DIV  = 434,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 byte_ready,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] HALF_M1  = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_M1  = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic                 r_rx_m;
  logic                 r_rx_s;
  logic [BW-1:0]        r_baud;
  logic [BW-1:0]        w_baud_nx;
  logic [CW-1:0]        r_bit;
  logic [CW-1:0]        w_bit_nx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nx;
  logic                 r_rdy;
  logic                 w_rdy_nx;
  logic                 r_ferr;
  logic                 w_ferr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_m  <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_rx_m  <= rx;
      r_rx_s  <= r_rx_m;
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_rdy   <= w_rdy_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + BW'(1);
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_rdy_nx   = 1'b0;
    w_ferr_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nx = '0;
        w_bit_nx  = '0;
        if (!r_rx_s) w_state_nx = START;
      end
      START: begin
        if (r_baud == HALF_M1) begin
          w_baud_nx  = '0;
          w_bit_nx   = '0;
          w_state_nx = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_baud == FULL_M1) begin
          w_baud_nx  = '0;
          w_shift_nx = {r_rx_s, r_shift[DATA_BITS-1:1]};
          w_bit_nx   = r_bit + CW'(1);
          if (r_bit == LAST_BIT) w_state_nx = STOP;
        end
      end
      STOP: begin
        if (r_baud == FULL_M1) begin
          // Leaving at mid-stop lets a gapless next start bit be caught
          w_baud_nx  = '0;
          w_state_nx = IDLE;
          if (r_rx_s) begin
            w_data_nx = r_shift;
            w_rdy_nx  = 1'b1;
          end else begin
            w_ferr_nx = 1'b1;
          end
        end
      end
      default: begin
        w_baud_nx  = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  assign rx_data    = r_data;
  assign byte_ready = r_rdy;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD_DIV=16, DATA_BITS=8.
// Frames push expected events; a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int B   = 16;
  localparam int H   = B / 2;
  localparam int LAT = H + 9 * B + 3;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       byte_ready;
  logic       frame_err;
  logic       busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   ferr_seen = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] last_good = 8'h00;
  exp_t sb[$];

  uart_rx #(.BAUD_DIV(B), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .byte_ready (byte_ready),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_ready && frame_err) begin
      n_cmp++;
      n_bad++;
      $display("FAIL excl: byte_ready and frame_err both high at cycle %0d", cyc);
    end
    if (prev_pulse && (byte_ready || frame_err)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_width: pulse high two cycles at cycle %0d", cyc);
    end
    if (byte_ready || frame_err) begin
      exp_t e;
      if (frame_err) ferr_seen++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected: rdy=%0b ferr=%0b data=%h at cycle %0d, none expected",
                 byte_ready, frame_err, rx_data, cyc);
      end else begin
        e = sb.pop_front();
        if (frame_err !== e.is_err || rx_data !== e.data) begin
          n_bad++;
          $display("FAIL event: got ferr=%0b data=%h, expected ferr=%0b data=%h",
                   frame_err, rx_data, e.is_err, e.data);
        end
        if (e.t0 >= 0) begin
          n_cmp++;
          if ((cyc - e.t0) < LAT - 1 || (cyc - e.t0) > LAT + 1) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, expected %0d +/-1",
                     cyc - e.t0, LAT);
          end
        end
      end
    end
    prev_pulse = byte_ready || frame_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t       e;
    logic [7:0] prev;
    prev = last_good;
    rx = 1'b0;
    e.t0 = cyc;
    e.is_err = ~stop;
    e.data = stop ? d : last_good;
    sb.push_back(e);
    if (stop) last_good = d;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(B);
    end
    n_cmp++;
    if (rx_data !== prev) begin
      n_bad++;
      $display("FAIL midframe_hold: rx_data=%h, expected %h", rx_data, prev);
    end
    rx = stop;
    tick(B);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 12 * B) begin
      tick(1);
      k++;
    end
    tick(4);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d events pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    n_cmp++;
    if (rx_data !== 8'h00 || byte_ready !== 1'b0 ||
        frame_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: data=%h rdy=%b ferr=%b busy=%b, expected 00 0 0 0",
               rx_data, byte_ready, frame_err, busy);
    end
    rst = 1'b0;
    tick(2 * B);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    wait_drain("single");
    n_cmp++;
    if (rx_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_data: rx_data=%h, expected a5", rx_data);
    end
  endtask

  task automatic test_glitch();
    logic saw;
    saw = 1'b0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    for (int i = 0; i < 2 * B; i++) begin
      if (busy === 1'b1) saw = 1'b1;
      tick(1);
    end
    n_cmp++;
    if (saw !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_rise: saw busy=%b, expected 1", saw);
    end
    n_cmp++;
    if (busy !== 1'b0 || rx_data !== last_good) begin
      n_bad++;
      $display("FAIL glitch_end: busy=%b data=%h, expected 0 %h",
               busy, rx_data, last_good);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    wait_drain("ferr");
    n_cmp++;
    if (rx_data !== 8'hA5 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ferr_hold: data=%h busy=%b, expected a5 0", rx_data, busy);
    end
  endtask

  task automatic test_back_to_back();
    tick(2 * B);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain("b2b");
    n_cmp++;
    if (rx_data !== 8'hFF) begin
      n_bad++;
      $display("FAIL b2b_data: rx_data=%h, expected ff", rx_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h81;
    tick(2 * B);
    rx = 1'b0;
    tick(B);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      tick(B);
    end
    rx = d[3];
    tick(H);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_busy_before: busy=%b, expected 1", busy);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx  = 1'b1;
    last_good = 8'h00;
    n_cmp++;
    if (busy !== 1'b0 || rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_after: busy=%b data=%h, expected 0 00", busy, rx_data);
    end
    tick(12 * B);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_idle: busy=%b, expected 0", busy);
    end
    send_frame(8'h5A, 1'b1);
    wait_drain("rstmid");
    n_cmp++;
    if (rx_data !== 8'h5A) begin
      n_bad++;
      $display("FAIL rstmid_data: rx_data=%h, expected 5a", rx_data);
    end
  endtask

  task automatic test_break();
    exp_t e;
    int   base;
    int   k;
    tick(2 * B);
    base = ferr_seen;
    e.is_err = 1'b1;
    e.data = last_good;
    e.t0 = -1;
    repeat (3) sb.push_back(e);
    rx = 1'b0;
    k = 0;
    while ((ferr_seen - base) < 3 && k < 40 * B) begin
      tick(1);
      k++;
    end
    rx = 1'b1;
    n_cmp++;
    if ((ferr_seen - base) !== 3) begin
      n_bad++;
      $display("FAIL break_count: saw %0d frame_err, expected 3", ferr_seen - base);
    end
    wait_drain("break");
    tick(2 * B);
    n_cmp++;
    if (rx_data !== 8'h5A || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL break_hold: data=%h busy=%b, expected 5a 0", rx_data, busy);
    end
    send_frame(8'h11, 1'b1);
    wait_drain("after_break");
    n_cmp++;
    if (rx_data !== 8'h11) begin
      n_bad++;
      $display("FAIL after_break_data: rx_data=%h, expected 11", rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_break();
    tick(4 * B);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL final_queue: %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 434, clock cycles per serial bit (even, >= 4).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame (fixed format: 1 start, DATA_BITS data LSB-first, 1 stop, no parity).
REQ-003 SHALL provide port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL provide port rx_data  output  DATA_BITS  last correctly framed received byte.
REQ-007 SHALL provide port byte_ready  output  1  one-cycle pulse: new valid byte on rx_data.
REQ-008 SHALL provide port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL provide port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; unreachable encodings SHALL go to IDLE.
REQ-012 SHALL use a baud counter (width ceil(log2(BAUD_DIV))) and a bit counter (width ceil(log2(DATA_BITS+1))).
REQ-013 IDLE: baud counter held at 0; when rx_s == 0, go to START.
REQ-014 START: baud counter increments each cycle; at count == BAUD_DIV/2-1, if rx_s == 0 go to DATA with baud and bit counters cleared; else go to IDLE (glitch rejected, no outputs pulsed).
REQ-015 DATA: at count == BAUD_DIV-1, shift rx_s into the MSB of the shift register (right shift, LSB-first), clear the baud counter, increment the bit counter; after the DATA_BITS-th sample go to STOP.
REQ-016 STOP: at count == BAUD_DIV-1, sample rx_s; if 1, load rx_data from the shift register and pulse byte_ready; if 0, pulse frame_err and leave rx_data unchanged; in both cases go to IDLE.
REQ-017 byte_ready and frame_err SHALL be registered, high for exactly one cycle (the cycle after the stop sample edge), and never high simultaneously.
REQ-018 Latency: byte_ready SHALL assert BAUD_DIV/2 + (DATA_BITS+1)*BAUD_DIV + 3 clocks (+/-1) after the rx start-bit falling edge.
REQ-019 Return to IDLE at mid-stop-bit SHALL allow a following start bit with zero idle gap to be received.
REQ-020 rx_data SHALL hold its value between frames; the shift register SHALL NOT be visible on rx_data mid-frame.
REQ-021 A line held low continuously (break) SHALL yield frame_err once per frame time, never byte_ready.

Reset
REQ-022 rst SHALL dominate all other conditions in its cycle.
REQ-023 On rst: state IDLE, synchronizer flops 1, counters 0, shift register 0, rx_data 0, byte_ready 0, frame_err 0, busy 0.
REQ-024 rst asserted mid-frame SHALL abort the frame with no byte_ready/frame_err pulse; busy low the cycle after rst is sampled.

Verification (BAUD_DIV=16, DATA_BITS=8)
REQ-025 Send 0xA5, stop=1 -> one byte_ready pulse, rx_data=0xA5, frame_err=0, timing per REQ-018.
REQ-026 Drive rx low for 4 clocks, then high -> busy rises then falls, no byte_ready, no frame_err, rx_data unchanged.
REQ-027 After 0xA5, send 0x3C with stop=0 -> one frame_err pulse, no byte_ready, rx_data stays 0xA5.
REQ-028 Send 0x00 then 0xFF back-to-back, one stop bit each, no idle gap -> two byte_ready pulses, rx_data 0x00 then 0xFF.
REQ-029 Assert rst for 1 cycle during data bit 3 of 0x81 -> busy=0 next cycle, no pulse; subsequent 0x5A received as 0x5A.
REQ-030 Hold rx low for 3 frame times -> frame_err pulses, never byte_ready; after rx returns high, 0x11 is received correctly.
